rom1p1r_stream_reader: RTL
==========================

// Module: rom1p1r_stream_reader
//
// PURPOSE
//  Read sequencer that sits directly upstream of the 128x64 single-port ROM wrapper.
//  It owns the ROM's CEB/A pins, so it is the only block that reads the ROM.
//  It takes a (start address, word count) request and reads consecutive ROM words.
//  It delivers the words on a valid/ready stream and absorbs the ROM's 1-cycle read
//  latency with a 2-entry skid FIFO, so downstream backpressure never loses data.
//
// PARAMETERS
//  ADDR_BITS   7    ROM address width (128 words)
//  DATA_BITS   64   ROM word width
//  FIFO_DEPTH  2    output skid entries; must be >= 2 to sustain 1 word/cycle
//
// PORTS
//  clk        in   1          single clock; ROM shares it
//  reset      in   1          asynchronous, active-high
//  Start      in   1          request strobe; accepted only in IDLE
//  StartAdr   in   ADDR_BITS  first ROM address
//  WordCount  in   ADDR_BITS+1  words to read, 0..128 (0 = empty request)
//  Busy       out  1          request in progress
//  Done       out  1          1-cycle pulse when request completes
//  DataValid  out  1          Data holds a valid ROM word
//  DataReady  in   1          consumer accepts Data this cycle
//  Data       out  DATA_BITS  ROM word, delivered in address order
//  RomCEB     out  1          ROM chip enable, active-low
//  RomA       out  ADDR_BITS  ROM address
//  RomQ       in   DATA_BITS  ROM output; valid the cycle after RomCEB=0
//
// BEHAVIOUR
//  Reset values
//   - FSM=IDLE; Busy=0, Done=0, DataValid=0, RomCEB=1, RomA=0.
//   - FIFO empty; in-flight flag=0; counters=0.
//   - Reset mid-request aborts the request. Any in-flight ROM word is discarded.
//  FSM states IDLE -> READ -> DRAIN -> IDLE
//   - IDLE, Start=1, WordCount!=0: latch AdrQ=StartAdr and IssueLeft=DeliverLeft=WordCount.
//     Busy=1 from the next cycle.
//   - IDLE, Start=1, WordCount=0: Done pulses in the next cycle. Busy stays 0 and no ROM access occurs.
//   - READ: issue a read when IssueLeft!=0 and credit is available. On issue:
//     RomCEB=0, RomA=AdrQ, AdrQ++ (wraps 127->0 modulo 2^ADDR_BITS), IssueLeft--.
//   - Issuing the last word (IssueLeft becomes 0) moves the FSM to DRAIN.
//   - DRAIN: no issues. When DeliverLeft reaches 0, go to IDLE and pulse Done.
//     In that same cycle Busy drops to 0.
//   - Start while Busy=1 is ignored; it is neither queued nor reported as an error.
//  Credit rule
//   - Issue is allowed when FifoCount + InFlight - Pop < FIFO_DEPTH.
//   - Pop = DataValid & DataReady, counted in the same cycle.
//   - This guarantees RomQ always has a free FIFO slot when it arrives. No overflow is possible.
//  Capture timing
//   - InFlight is set on issue and clears the next cycle.
//   - In that cycle RomQ is pushed into the FIFO.
//   - Simultaneous push and pop keep FifoCount unchanged.
//  Output side
//   - DataValid = FIFO non-empty; Data = FIFO head.
//   - Data is stable while DataValid=1 & DataReady=0.
//   - Each pop decrements DeliverLeft.
//  Latency
//   - Start accepted at cycle 0 -> RomCEB=0 at cycle 1 -> DataValid=1 at cycle 2.
//   - With DataReady held at 1: one word per cycle, and the last word appears at cycle WordCount+1.
//   - Done pulses the cycle after the last pop.
//  RomCEB=1 whenever no issue occurs, to save ROM power. RomA holds its last value while RomCEB=1.
//
// STRUCTURE
//  Shared package rom_stream_pkg
//   - typedef enum logic [1:0] {IDLE, READ, DRAIN} romrd_state_t
//   - localparams ROM_ADDR_BITS=7, ROM_DATA_BITS=64
//  Sub-module rom_skid_fifo
//   - parameterised depth/width; push/pop/count/head ports; register-based storage.
//  Top level: FSM, address/issue/deliver counters, credit logic, in-flight flag.
//
// TESTING (bench uses a behavioural ROM model with word[i] = {32'hC0DE0000|i, 32'(~i)})
//  1. Start=1, StartAdr=5, WordCount=4, DataReady=1
//     -> RomA=5,6,7,8 on cycles 1-4; Data=word[5..8] on cycles 2-5; Done at cycle 6.
//  2. StartAdr=126, WordCount=4 -> Data order word[126], word[127], word[0], word[1]; address wraps.
//  3. WordCount=8, DataReady toggled 1,0,0,1 pseudo-randomly
//     -> all 8 words in order, none dropped or duplicated.
//     -> FifoCount+InFlight never exceeds 2; Data stable while stalled.
//  4. WordCount=0 -> Done pulse at cycle 1; RomCEB stays 1; DataValid stays 0.
//  5. WordCount=128, StartAdr=0, DataReady=1 -> 128 words, back-to-back, Done at cycle 130.
//     A second Start issued mid-request is ignored.
//  6. Assert reset during cycle 3 of a WordCount=10 request
//     -> outputs immediately take reset values.
//     -> a new request after reset returns data from its own StartAdr.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared types and sizes for the ROM stream reader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_stream_pkg;

  localparam int ROM_ADDR_BITS  = 7;
  localparam int ROM_DATA_BITS  = 64;
  localparam int ROM_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } romrd_state_t;

endpackage

// File: rtl/rom_skid_fifo.sv
// Register-based FIFO that holds ROM words until the consumer takes them.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: none internally; the caller must never push when full or pop when empty.
//
// Ports: clk, reset (async, active-high), push/push_dat (write), pop (drop head),
//        count (entries held), head (oldest entry, meaningful when count != 0).
module rom_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom1p1r_stream_reader.sv
// Reads WordCount consecutive ROM words from StartAdr and streams them out in order.
// Latency: Start at cycle 0 -> RomCEB low at cycle 1 -> first DataValid at cycle 2, then 1 word/cycle.
// Backpressure: DataReady low stalls issue via credits; no word is ever dropped.
//
// Ports: clk, reset (async, active-high); request Start/StartAdr/WordCount; status Busy/Done;
//        stream DataValid/DataReady/Data; ROM side RomCEB/RomA (driven) and RomQ (returned).
module rom1p1r_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_BITS  = ROM_ADDR_BITS,
  parameter int DATA_BITS  = ROM_DATA_BITS,
  parameter int FIFO_DEPTH = ROM_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [ADDR_BITS-1:0] StartAdr,
  input  logic [ADDR_BITS:0]   WordCount,
  output logic                 Busy,
  output logic                 Done,
  output logic                 DataValid,
  input  logic                 DataReady,
  output logic [DATA_BITS-1:0] Data,
  output logic                 RomCEB,
  output logic [ADDR_BITS-1:0] RomA,
  input  logic [DATA_BITS-1:0] RomQ
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  romrd_state_t         state;
  logic [ADDR_BITS-1:0] adr_q;
  logic [ADDR_BITS-1:0] rom_a_hold;
  logic [ADDR_BITS:0]   issue_left;
  logic [ADDR_BITS:0]   deliver_left;
  logic [ADDR_BITS:0]   deliver_next;
  logic                 in_flight;
  logic                 pop;
  logic                 issue;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          occupancy;
  logic [DATA_BITS-1:0] fifo_head;

  // The word returning from the ROM is offered straight to the consumer when
  // nothing older is queued; it is only written into the FIFO if not taken.
  assign fifo_empty = (fifo_count == '0);
  assign DataValid  = ~fifo_empty | in_flight;
  assign Data       = fifo_empty ? RomQ : fifo_head;
  assign pop        = DataValid & DataReady;
  assign fifo_pop   = pop & ~fifo_empty;
  assign fifo_push  = in_flight & ~(fifo_empty & pop);

  // Slots committed after this edge: stored + returning - leaving. Issuing only
  // below FIFO_DEPTH guarantees the returning word always has a slot.
  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(in_flight) - (CW + 1)'(pop);
  assign issue     = (state == READ) && (issue_left != '0) &&
                     (occupancy < (CW + 1)'(FIFO_DEPTH));

  // The ROM is only enabled on an issue; the address holds otherwise.
  assign RomCEB = ~issue;
  assign RomA   = issue ? adr_q : rom_a_hold;

  assign deliver_next = deliver_left - {{ADDR_BITS{1'b0}}, pop};

  rom_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (RomQ),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      adr_q        <= '0;
      rom_a_hold   <= '0;
      issue_left   <= '0;
      deliver_left <= '0;
      in_flight    <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      Done         <= 1'b0;
      in_flight    <= issue;
      deliver_left <= deliver_next;

      if (issue) begin
        rom_a_hold <= adr_q;
        adr_q      <= adr_q + ADDR_BITS'(1);
        issue_left <= issue_left - (ADDR_BITS + 1)'(1);
      end

      case (state)
        IDLE: begin
          // Start is only looked at here, so a Start during a request is dropped.
          if (Start) begin
            if (WordCount != '0) begin
              adr_q        <= StartAdr;
              issue_left   <= WordCount;
              deliver_left <= WordCount;
              Busy         <= 1'b1;
              state        <= READ;
            end else begin
              Done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue && (issue_left == (ADDR_BITS + 1)'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (deliver_next == '0) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
